// File: rtl/rr_demux_sched_if.sv
// Handshake bundle between one producer, the round-robin scheduler and four sinks.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface rr_demux_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            en;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [3:0]            out_ready;
  logic [3:0]            out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            sel;
  logic                  burst_done;
  logic                  timeout;

  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, burst_done, timeout
  );

  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, burst_done, timeout
  );
endinterface

// File: rtl/rr_demux_sched.sv
// Round-robin scheduler sharing one valid/ready stream across four sinks in bursts,
// with a per-grant stall timeout and a dead HOP cycle between grants.
module rr_demux_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_demux_sched_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HOP  = 2'd2;

  localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam bit         TO_ON     = (TIMEOUT != 0);

  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       burst_done_q, burst_done_d;
  logic       timeout_q, timeout_d;

  logic [3:0] out_valid_w;
  logic       in_ready_w;
  logic       xfer_w;

  // First enabled index scanning start, start+1, ... (mod 4); lowest offset wins.
  function automatic logic [1:0] first_en(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    first_en = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) first_en = idx;
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    burst_done_d = 1'b0;
    timeout_d    = 1'b0;
    out_valid_w  = 4'b0000;
    in_ready_w   = 1'b0;
    xfer_w       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.en) begin
          sel_d      = first_en(bus.en, sel_q);
          beat_cnt_d = 8'd0;
          wait_cnt_d = 8'd0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        out_valid_w[sel_q] = bus.in_valid & bus.en[sel_q];
        in_ready_w         = bus.out_ready[sel_q] & bus.en[sel_q];
        xfer_w             = bus.in_valid & in_ready_w;
        // A disabled grant wins over everything, including a would-be final beat.
        if (!bus.en[sel_q]) begin
          state_d = S_HOP;
        end else if (xfer_w) begin
          if (beat_cnt_q == BEAT_LAST) begin
            state_d      = S_HOP;
            burst_done_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            wait_cnt_d = 8'd0;
          end
        end else if (bus.in_valid && !bus.out_ready[sel_q] && TO_ON) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = S_HOP;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      S_HOP: begin
        if (bus.en == 4'b0000) begin
          state_d = S_IDLE;
        end else begin
          // Current index is scanned last so the other sinks get their turn first.
          sel_d      = first_en(bus.en, sel_q + 2'd1);
          beat_cnt_d = 8'd0;
          wait_cnt_d = 8'd0;
          state_d    = S_SEND;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'd0;
      beat_cnt_q   <= 8'd0;
      wait_cnt_q   <= 8'd0;
      burst_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_done_q <= burst_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.out_valid  = out_valid_w;
  assign bus.in_ready   = in_ready_w;
  assign bus.out_data   = DATA_WIDTH'(bus.in_data);
  assign bus.sel        = sel_q;
  assign bus.burst_done = burst_done_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: doc/rr_demux_sched.md
# rr_demux_sched

Round-robin scheduler that shares a single valid/ready input stream between four consumers.
- It drives the 2-bit select of a 1-to-4 demultiplexer and gates the per-output valid strobes.
- It forwards bursts of BURST_LEN words to one consumer, then hops to the next enabled consumer.
- A stalled consumer is abandoned after a programmable timeout.
- It sits between a single producer and four downstream sinks, with in_data broadcast to all sinks.

## Interface
- DATA_WIDTH, 8, width of in_data/out_data
- BURST_LEN, 4, words per grant (1..255)
- TIMEOUT, 16, consecutive stalled cycles before abandoning a grant; 0 disables the timeout (1..255 otherwise)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  4  consumer enable mask; bit i enables output i
- in_valid  input  1  producer has a word
- in_data  input  DATA_WIDTH  producer word
- in_ready  output  1  word accepted this cycle when high together with in_valid
- out_ready  input  4  per-consumer ready
- out_valid  output  4  per-consumer valid; at most one bit high (one-hot or zero)
- out_data  output  DATA_WIDTH  equals in_data (combinational broadcast)
- sel  output  2  current grant index; drives the demux select
- burst_done  output  1  one-cycle pulse after a completed full burst
- timeout  output  1  one-cycle pulse after a grant is abandoned for stall

## Operation
- State machine states: IDLE, SEND, HOP.
- Registers: state, sel, beat_cnt (8 bit), wait_cnt (8 bit), burst_done, timeout.
- Reset values:
  - state=IDLE, sel=0, beat_cnt=0, wait_cnt=0, burst_done=0, timeout=0.
  - Hence in_ready=0 and out_valid=0 during reset.
- Combinational outputs in SEND:
  - out_valid[sel] = in_valid & en[sel].
  - in_ready = out_ready[sel] & en[sel].
  - All other out_valid bits are 0.
- Combinational outputs in IDLE and HOP: out_valid=0 and in_ready=0.
- Transfer condition: state==SEND & in_valid & in_ready.
- IDLE:
  - If en==0, stay in IDLE.
  - Otherwise load sel with the first enabled index scanning sel, sel+1, ... (mod 4), clear both counters, and go to SEND.
- SEND, evaluated in priority order:
  - 1. en[sel]==0: go to HOP. No pulse.
  - 2. Transfer with beat_cnt==BURST_LEN-1: go to HOP and set burst_done.
  - 3. Other transfer: beat_cnt+1, wait_cnt=0.
  - 4. in_valid & ~out_ready[sel] & TIMEOUT!=0:
    - If wait_cnt==TIMEOUT-1, go to HOP and set timeout.
    - Otherwise wait_cnt+1.
  - 5. in_valid==0: wait_cnt holds. Producer idle is not counted as a stall.
- HOP:
  - Scan order is sel+1, sel+2, sel+3, sel (mod 4). The current index is eligible last.
  - If en==0, go to IDLE and keep sel.
  - Otherwise load sel with the first enabled index, clear both counters, and go to SEND.
- burst_done and timeout are registered. Each is high exactly during the HOP cycle that follows its cause; otherwise 0.
- Counter wrap:
  - beat_cnt never exceeds BURST_LEN-1.
  - wait_cnt never exceeds TIMEOUT-1.
  - Both are cleared on every entry to SEND.

## Timing
- Zero-latency pass-through: a word presented in SEND is delivered to the granted consumer in the same cycle.
- Each grant costs one dead HOP cycle.
- Cost of a full burst with no stalls: BURST_LEN transfer cycles + 1 HOP cycle.
- IDLE to SEND takes 1 cycle after en becomes nonzero.
- Simultaneous events:
  - en[sel] falling in the same cycle as a final transfer: rule 1 wins. No transfer occurs (in_ready=0) and no burst_done pulse.
- Changes to en bits other than sel take effect at the next scan only.
- Asserting rst_n low mid-burst:
  - Outputs go to their reset values immediately (asynchronous).
  - The partial burst is discarded with no pulse.
  - After release, scheduling restarts from index 0.
- The producer must hold in_data stable while in_valid=1 and in_ready=0.

## Test plan
- Default parameters (BURST_LEN=4), en=4'b1111, in_valid and all out_ready tied high, after reset:
  - sel sequence is 0,0,0,0,H,1,1,1,1,H,2...; out_valid one-hot follows sel.
  - burst_done pulses on every HOP cycle, i.e. every 5th cycle.
- en=4'b1010 with continuous traffic:
  - Grants alternate 1 → 3 → 1; outputs 0 and 2 never see out_valid.
- sel=2, out_ready[2]=0, in_valid=1, TIMEOUT=16:
  - After 16 stalled cycles, timeout pulses once and the next grant is 3.
  - beat_cnt is cleared.
  - No word is lost: in_data is held until accepted.
- en[sel] dropped in the cycle of the 4th transfer:
  - No transfer and no burst_done that cycle.
  - HOP follows; the word is delivered later to the next enabled consumer.
- en=4'b0000 after reset: stays in IDLE, out_valid=0, in_ready=0. Setting en=4'b0100 gives sel=2 in SEND one cycle later.
- rst_n pulsed low mid-burst (sel=1, beat_cnt=2):
  - Outputs go to 0 immediately.
  - After release, the first grant is sel=0 and a full 4-word burst completes.
